// File: rtl/spi_pkg.sv
// Shared frame geometry and FSM state encoding for the SPI write-frame controller.
package spi_pkg;
  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam logic WRITE_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT_HI,
    SHIFT_LO,
    TRAIL,
    GAP
  } state_t;
endpackage

// File: rtl/spi_controller_tx_if.sv
// Valid/ready command channel feeding the SPI write-frame controller.
interface spi_controller_tx_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/spi_tick_gen.sv
// Emits a one-cycle tick every CLK_DIV cycles while run is high; the count restarts whenever run drops.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);
  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == TERM) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  assign tick = run && (r_div_cnt == TERM);
endmodule

// File: rtl/spi_controller_tx.sv
// SPI mode-0 initiator: serializes {1, addr, data} as a 16-bit MSB-first write frame.
module spi_controller_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  spi_controller_tx_if.slave  cmd,
  output logic                busy,
  output logic                done,
  output logic                sclk,
  output logic                copi,
  output logic                ncs
);
  state_t             r_state, w_state_next;
  logic [FRAME_W-1:0] r_shift, w_shift_next;
  logic [3:0]         r_bit_cnt, w_bit_cnt_next;
  logic               r_sclk, w_sclk_next;
  logic               r_ncs, w_ncs_next;
  logic               r_ready, w_ready_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               w_tick;
  logic               w_accept;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (r_state != IDLE),
    .tick (w_tick)
  );

  assign w_accept = (r_state == IDLE) && cmd.cmd_valid && r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_ncs     <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_sclk    <= w_sclk_next;
      r_ncs     <= w_ncs_next;
      r_ready   <= w_ready_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:     if (w_accept) w_state_next = LEAD;
      LEAD:     if (w_tick) w_state_next = SHIFT_HI;
      SHIFT_HI: if (w_tick) w_state_next = (r_bit_cnt == 4'd15) ? TRAIL : SHIFT_LO;
      SHIFT_LO: if (w_tick) w_state_next = SHIFT_HI;
      TRAIL:    if (w_tick) w_state_next = GAP;
      GAP:      if (w_tick) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // COPI is the shift register MSB, so it only moves on the edge that drops SCLK.
  always_comb begin
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_sclk_next    = r_sclk;
    w_ncs_next     = r_ncs;
    w_ready_next   = r_ready;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shift_next   = {WRITE_BIT, cmd.cmd_addr, cmd.cmd_data};
          w_bit_cnt_next = '0;
          w_ncs_next     = 1'b0;
          w_ready_next   = 1'b0;
          w_busy_next    = 1'b1;
        end
      end
      LEAD: if (w_tick) w_sclk_next = 1'b1;
      SHIFT_HI: begin
        if (w_tick) begin
          w_sclk_next = 1'b0;
          if (r_bit_cnt != 4'd15) begin
            w_shift_next   = {r_shift[FRAME_W-2:0], 1'b0};
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end
      end
      SHIFT_LO: if (w_tick) w_sclk_next = 1'b1;
      TRAIL: begin
        if (w_tick) begin
          w_ncs_next   = 1'b1;
          w_shift_next = '0;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_done_next  = 1'b1;
          w_ready_next = 1'b1;
          w_busy_next  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign cmd.cmd_ready = r_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sclk          = r_sclk;
  assign copi          = r_shift[FRAME_W-1];
  assign ncs           = r_ncs;
endmodule

// File: tb/tb_spi_controller_tx.sv
// Directed bench: a CLK_DIV=4 controller decoded by a frame monitor, plus a CLK_DIV=2 controller for phase timing.
module tb_spi_controller_tx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_controller_tx_if if4 ();
  spi_controller_tx_if if2 ();

  logic w_busy4, w_done4, w_sclk4, w_copi4, w_ncs4;
  logic w_busy2, w_done2, w_sclk2, w_copi2, w_ncs2;

  spi_controller_tx #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd(if4),
    .busy(w_busy4), .done(w_done4), .sclk(w_sclk4), .copi(w_copi4), .ncs(w_ncs4)
  );

  spi_controller_tx #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .cmd(if2),
    .busy(w_busy2), .done(w_done2), .sclk(w_sclk2), .copi(w_copi2), .ncs(w_ncs2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame monitor for the CLK_DIV=4 instance; everything is observed on the falling clk edge.
  logic [15:0] q_frame[$];
  int          q_edges[$];
  int          q_low[$];
  int          q_lat[$];
  logic [15:0] m_shift;
  int          m_edges, m_low, m_high, m_last_gap, m_fall_cyc, m_viol, m_done_cnt, cyc;
  logic        m_prev_sclk, m_prev_ncs, m_prev_copi, m_seen;

  initial begin
    m_shift = '0; m_edges = 0; m_low = 0; m_high = 0; m_last_gap = 0;
    m_fall_cyc = 0; m_viol = 0; m_done_cnt = 0; cyc = 0;
    m_prev_sclk = 1'b0; m_prev_ncs = 1'b1; m_prev_copi = 1'b0; m_seen = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (w_ncs4 === 1'b1 && m_prev_ncs === 1'b0) begin
        q_frame.push_back(m_shift);
        q_edges.push_back(m_edges);
        q_low.push_back(m_low);
        m_high = 0;
        m_seen = 1'b1;
      end
      if (w_ncs4 === 1'b0 && m_prev_ncs === 1'b1) begin
        if (m_seen) m_last_gap = m_high;
        m_shift = '0; m_edges = 0; m_low = 0; m_fall_cyc = cyc;
      end
      if (w_ncs4 === 1'b1) m_high++;
      else if (w_ncs4 === 1'b0) m_low++;
      if (w_sclk4 === 1'b1 && m_prev_sclk === 1'b0 && w_ncs4 === 1'b0) begin
        m_shift = {m_shift[14:0], w_copi4};
        m_edges++;
      end
      if (w_sclk4 === 1'b1 && m_prev_sclk === 1'b1 && w_copi4 !== m_prev_copi) m_viol++;
      if (w_done4 === 1'b1) begin
        m_done_cnt++;
        q_lat.push_back(cyc - m_fall_cyc);
      end
      m_prev_sclk = w_sclk4;
      m_prev_ncs  = w_ncs4;
      m_prev_copi = w_copi4;
    end
  end

  task automatic clear_q();
    q_frame.delete(); q_edges.delete(); q_low.delete(); q_lat.delete();
  endtask

  task automatic send4(input logic [6:0] a, input logic [7:0] d, input bit tog);
    int n;
    @(negedge clk);
    if4.cmd_valid = 1'b1; if4.cmd_addr = a; if4.cmd_data = d;
    @(posedge clk); #1;
    if4.cmd_valid = 1'b0;
    n = 0;
    while (w_done4 !== 1'b1 && n < 400) begin
      @(negedge clk); n++;
      if (tog) begin
        if4.cmd_addr = 7'($urandom);
        if4.cmd_data = 8'($urandom);
      end
    end
    checks++;
    if (w_done4 !== 1'b1) begin
      errors++; $display("FAIL send4_timeout done=%b required=1", w_done4);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (w_ncs4 !== 1'b1) begin errors++; $display("FAIL reset_ncs got=%b exp=1", w_ncs4); end
    checks++; if (w_sclk4 !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", w_sclk4); end
    checks++; if (w_copi4 !== 1'b0) begin errors++; $display("FAIL reset_copi got=%b exp=0", w_copi4); end
    checks++; if (if4.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", if4.cmd_ready); end
    checks++; if (w_busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", w_busy4); end
    checks++; if (w_done4 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", w_done4); end
    checks++; if (w_ncs2 !== 1'b1 || if2.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_div2 ncs=%b ready=%b exp=1/1", w_ncs2, if2.cmd_ready); end
    rst = 1'b0;
    $display("reset: ncs=%b sclk=%b ready=%b busy=%b", w_ncs4, w_sclk4, if4.cmd_ready, w_busy4);
  endtask

  task automatic test_basic();
    int d0;
    clear_q();
    d0 = m_done_cnt;
    send4(7'h00, 8'hA5, 1'b0);
    checks++;
    if (q_frame.size() != 1 || q_lat.size() != 1) begin
      errors++; $display("FAIL basic_count frames=%0d lat=%0d exp=1/1", q_frame.size(), q_lat.size());
    end else begin
      checks++; if (q_frame[0] !== 16'h80A5) begin errors++; $display("FAIL basic_frame got=%h exp=80a5", q_frame[0]); end
      checks++; if (q_edges[0] != 16) begin errors++; $display("FAIL basic_edges got=%0d exp=16", q_edges[0]); end
      // LEAD + 31 half-periods + TRAIL = 33 * 4 cycles with ncs low
      checks++; if (q_low[0] != 132) begin errors++; $display("FAIL basic_ncs_low got=%0d exp=132", q_low[0]); end
      checks++; if (q_lat[0] != 136) begin errors++; $display("FAIL basic_latency got=%0d exp=136", q_lat[0]); end
      $display("basic: frame=%h edges=%0d ncs_low=%0d latency=%0d", q_frame[0], q_edges[0], q_low[0], q_lat[0]);
    end
    checks++; if (m_done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_len got=%0d exp=1", m_done_cnt - d0); end
    checks++; if (if4.cmd_ready !== 1'b1 || w_busy4 !== 1'b0) begin errors++; $display("FAIL basic_idle ready=%b busy=%b exp=1/0", if4.cmd_ready, w_busy4); end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_q();
    @(negedge clk);
    if4.cmd_valid = 1'b1; if4.cmd_addr = 7'h01; if4.cmd_data = 8'h0F;
    @(posedge clk); #1;
    if4.cmd_addr = 7'h02; if4.cmd_data = 8'hF0;
    @(negedge clk);
    checks++; if (if4.cmd_ready !== 1'b0 || w_busy4 !== 1'b1) begin errors++; $display("FAIL b2b_busy ready=%b busy=%b exp=0/1", if4.cmd_ready, w_busy4); end
    n = 0;
    while (if4.cmd_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (w_done4 !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_done done=%b exp=1", w_done4); end
    @(posedge clk); #1;
    if4.cmd_valid = 1'b0;
    n = 0;
    while (w_done4 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (w_done4 !== 1'b1) begin errors++; $display("FAIL b2b_timeout done=%b exp=1", w_done4); end
    repeat (3) @(negedge clk);
    checks++;
    if (q_frame.size() != 2) begin
      errors++; $display("FAIL b2b_count got=%0d exp=2", q_frame.size());
    end else begin
      checks++; if (q_frame[0] !== 16'h810F) begin errors++; $display("FAIL b2b_frame0 got=%h exp=810f", q_frame[0]); end
      checks++; if (q_frame[1] !== 16'h82F0) begin errors++; $display("FAIL b2b_frame1 got=%h exp=82f0", q_frame[1]); end
      $display("b2b: frame0=%h frame1=%h gap=%0d", q_frame[0], q_frame[1], m_last_gap);
    end
    checks++; if (m_last_gap != 5) begin errors++; $display("FAIL b2b_gap got=%0d exp=5", m_last_gap); end
  endtask

  task automatic test_reset_midframe();
    int n, d0;
    @(negedge clk);
    if4.cmd_valid = 1'b1; if4.cmd_addr = 7'h15; if4.cmd_data = 8'h3C;
    @(posedge clk); #1;
    if4.cmd_valid = 1'b0;
    n = 0;
    while (m_edges < 8 && n < 400) begin @(negedge clk); n++; end
    d0 = m_done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (w_ncs4 !== 1'b1 || w_sclk4 !== 1'b0) begin errors++; $display("FAIL midrst_pins ncs=%b sclk=%b exp=1/0", w_ncs4, w_sclk4); end
    checks++; if (w_busy4 !== 1'b0 || w_done4 !== 1'b0) begin errors++; $display("FAIL midrst_status busy=%b done=%b exp=0/0", w_busy4, w_done4); end
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (m_done_cnt != d0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=%0d", m_done_cnt, d0); end
    clear_q();
    send4(7'h15, 8'h3C, 1'b0);
    checks++;
    if (q_frame.size() != 1) begin
      errors++; $display("FAIL midrst_count got=%0d exp=1", q_frame.size());
    end else begin
      checks++; if (q_frame[0] !== 16'h953C || q_edges[0] != 16) begin errors++; $display("FAIL midrst_frame got=%h/%0d exp=953c/16", q_frame[0], q_edges[0]); end
      $display("midrst: recovered frame=%h edges=%0d", q_frame[0], q_edges[0]);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] regs [128];
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    clear_q();
    send4(7'h04, 8'h80, 1'b0);
    send4(7'h00, 8'hFF, 1'b0);
    // Decode captured frames the way the register peripheral would.
    foreach (q_frame[i]) if (q_frame[i][15]) regs[q_frame[i][14:8]] = q_frame[i][7:0];
    checks++; if (regs[4] !== 8'h80) begin errors++; $display("FAIL loop_pwm got=%h exp=80", regs[4]); end
    checks++; if (regs[0] !== 8'hFF) begin errors++; $display("FAIL loop_en got=%h exp=ff", regs[0]); end
    $display("loopback: reg4=%h reg0=%h", regs[4], regs[0]);
  endtask

  task automatic test_verbatim();
    clear_q();
    send4(7'h7F, 8'h3C, 1'b1);
    checks++;
    if (q_frame.size() != 1) begin
      errors++; $display("FAIL verb_count got=%0d exp=1", q_frame.size());
    end else begin
      checks++; if (q_frame[0] !== 16'hFF3C) begin errors++; $display("FAIL verb_frame got=%h exp=ff3c", q_frame[0]); end
      $display("verbatim: frame=%h", q_frame[0]);
    end
    checks++; if (m_viol != 0) begin errors++; $display("FAIL copi_stable_high got=%0d exp=0", m_viol); end
  endtask

  task automatic test_clkdiv2();
    int n, run, hi, lo, bad, done_at;
    logic prev;
    logic [15:0] fr;
    @(negedge clk);
    if2.cmd_valid = 1'b1; if2.cmd_addr = 7'h55; if2.cmd_data = 8'h96;
    @(posedge clk); #1;
    if2.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (w_busy2 !== 1'b1 || w_ncs2 !== 1'b0) begin errors++; $display("FAIL div2_start busy=%b ncs=%b exp=1/0", w_busy2, w_ncs2); end
    n = 0; prev = w_sclk2; run = 1; hi = 0; lo = 0; bad = 0; done_at = -1; fr = '0;
    while (done_at < 0 && n < 200) begin
      @(negedge clk); n++;
      if (w_sclk2 !== prev) begin
        if (prev) hi++;
        else begin lo++; fr = {fr[14:0], w_copi2}; end
        if (run != 2) bad++;
        run = 1;
      end else run++;
      prev = w_sclk2;
      if (w_done2 === 1'b1) done_at = n;
    end
    checks++; if (done_at != 68) begin errors++; $display("FAIL div2_len got=%0d exp=68", done_at); end
    checks++; if (hi != 16 || lo != 16) begin errors++; $display("FAIL div2_phases hi=%0d lo=%0d exp=16/16", hi, lo); end
    checks++; if (bad != 0) begin errors++; $display("FAIL div2_phase_len bad=%0d exp=0", bad); end
    checks++; if (fr !== 16'hD596) begin errors++; $display("FAIL div2_frame got=%h exp=d596", fr); end
    $display("clkdiv2: frame=%h len=%0d hi=%0d lo=%0d", fr, done_at, hi, lo);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    if4.cmd_valid = 1'b0; if4.cmd_addr = '0; if4.cmd_data = '0;
    if2.cmd_valid = 1'b0; if2.cmd_addr = '0; if2.cmd_data = '0;
    test_reset();
    repeat (2) @(negedge clk);
    test_basic();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    test_verbatim();
    test_clkdiv2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
